// File: rtl/ahb_sram_slave.sv
// AHB-style SRAM slave: pipelined address/data phases, byte/half/word access,
// programmable wait states and two-cycle ERROR response for illegal accesses.
module ahb_sram_slave #(
    parameter int          ADDR_W      = 12,
    parameter logic [31:0] BASE        = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBUST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic [1:0]  HRESP
);
    localparam int         IDX_W  = ADDR_W - 2;
    localparam int         WORDS  = 1 << IDX_W;
    localparam logic [1:0] WS_CNT = 2'(WAIT_STATES);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t           state, state_nxt;
    logic [1:0]       cnt, cnt_nxt;
    logic             dp_write;
    logic [IDX_W-1:0] dp_idx;
    logic [1:0]       dp_lo;
    logic [1:0]       dp_size;
    logic [31:0]      mem [WORDS];

    logic             accept, acc_err, wr_done;
    logic [IDX_W-1:0] acc_idx;
    logic [3:0]       be;
    logic [31:0]      wr_merged, rd_word;
    logic             unused_bits;

    assign unused_bits = ^{HBUST, HTRANS[0]};

    assign acc_idx = HADDR[ADDR_W-1:2];
    assign accept  = HSEL & HTRANS[1] & HREADY & HREADYOUT;
    assign acc_err = (HSIZE > 3'b010)
                   | ((HSIZE == 3'b001) & HADDR[0])
                   | ((HSIZE == 3'b010) & (|HADDR[1:0]))
                   | (HADDR[31:ADDR_W] != BASE[31:ADDR_W]);
    assign wr_done = (state == S_DATA) & dp_write;

    always_comb begin
        be = 4'b1111;
        case (dp_size)
            2'b00:   be = 4'b0001 << dp_lo;
            2'b01:   be = dp_lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // A read accepted while a write to the same word completes sees the merged word.
    always_comb begin
        wr_merged = mem[dp_idx];
        for (int i = 0; i < 4; i++) begin
            if (be[i]) wr_merged[8*i +: 8] = HWDATA[8*i +: 8];
        end
        rd_word = (wr_done && (dp_idx == acc_idx)) ? wr_merged : mem[acc_idx];
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        HREADYOUT = 1'b1;
        HRESP     = 2'b00;
        case (state)
            S_WAIT: begin
                HREADYOUT = 1'b0;
                if (cnt == 2'd1) state_nxt = S_DATA;
                else             cnt_nxt   = cnt - 2'd1;
            end
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 2'b01;
                state_nxt = S_ERR2;
            end
            default: begin
                if (state == S_ERR2) HRESP = 2'b01;
                if (!accept) begin
                    state_nxt = S_IDLE;
                end else if (acc_err) begin
                    state_nxt = S_ERR1;
                end else if (WAIT_STATES > 0) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = WS_CNT;
                end else begin
                    state_nxt = S_DATA;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= 2'd0;
            dp_write <= 1'b0;
            dp_idx   <= '0;
            dp_lo    <= 2'b00;
            dp_size  <= 2'b00;
            HRDATA   <= 32'h0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                dp_write <= HWRITE & ~acc_err;
                dp_idx   <= acc_idx;
                dp_lo    <= HADDR[1:0];
                dp_size  <= HSIZE[1:0];
                if (!acc_err && !HWRITE) HRDATA <= rd_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_done) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[dp_idx][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: two instances (zero and two wait states) driven by
// pipelined directed and random transfers, checked against a byte-array model.
module tb_ahb_sram_slave;
    localparam logic [31:0] B0  = 32'h0000_3000;
    localparam logic [31:0] B1  = 32'h0000_0000;
    localparam int          WS0 = 0;
    localparam int          WS1 = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        hsel0, hsel1;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        hready0, hready1;
    logic        hreadyout0, hreadyout1;
    logic [31:0] hrdata0, hrdata1;
    logic [1:0]  hresp0, hresp1;

    always #5 clk = ~clk;

    assign hready0 = hreadyout0;
    assign hready1 = hreadyout1;

    ahb_sram_slave #(.ADDR_W(12), .BASE(B0), .WAIT_STATES(WS0)) dut0 (
        .clk(clk), .reset(reset), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBUST(hburst), .HWDATA(hwdata),
        .HREADY(hready0), .HREADYOUT(hreadyout0), .HRDATA(hrdata0), .HRESP(hresp0));

    ahb_sram_slave #(.ADDR_W(12), .BASE(B1), .WAIT_STATES(WS1)) dut1 (
        .clk(clk), .reset(reset), .HSEL(hsel1), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBUST(hburst), .HWDATA(hwdata),
        .HREADY(hready1), .HREADYOUT(hreadyout1), .HRDATA(hrdata1), .HRESP(hresp1));

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
    } op_t;

    op_t         ops[$];
    logic [7:0]  mdl [2][4096];
    logic [31:0] last_rd [2];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] base_of(input int w);
        return (w == 1) ? B1 : B0;
    endfunction

    function automatic int ws_of(input int w);
        return (w == 1) ? WS1 : WS0;
    endfunction

    function automatic op_t mk(input logic sel, input logic [1:0] trans, input logic wr,
                               input logic [2:0] size, input logic [31:0] addr,
                               input logic [31:0] data);
        op_t o;
        o.sel = sel; o.trans = trans; o.wr = wr; o.size = size; o.addr = addr; o.data = data;
        return o;
    endfunction

    function automatic bit is_err(input int w, input op_t o);
        longint unsigned a = 64'(o.addr);
        longint unsigned b = 64'(base_of(w));
        if (o.size > 3'd2) return 1'b1;
        if (o.size == 3'd1 && o.addr[0]) return 1'b1;
        if (o.size == 3'd2 && o.addr[1:0] != 2'b00) return 1'b1;
        return (a < b) || (a >= b + 64'd4096);
    endfunction

    // Memory model: byte array; a read returns the enclosing aligned word.
    function automatic logic [31:0] mdl_word(input int w, input logic [31:0] addr);
        int off = int'((addr - base_of(w)) & 32'h0000_0FFC);
        return {mdl[w][off+3], mdl[w][off+2], mdl[w][off+1], mdl[w][off]};
    endfunction

    task automatic mdl_write(input int w, input op_t o);
        int off = int'(o.addr - base_of(w));
        int n = 1 << o.size;
        for (int k = 0; k < n; k++) begin
            int p = off + k;
            mdl[w][p] = o.data[8*(p % 4) +: 8];
        end
    endtask

    task automatic drive_idle();
        hsel0 = 1'b0; hsel1 = 1'b0; htrans = 2'b00; hwrite = 1'b0;
        hsize = 3'd0; haddr = 32'h0; hburst = 3'd0;
    endtask

    task automatic drive(input op_t o, input int w);
        hsel0  = (w == 0) && o.sel;
        hsel1  = (w == 1) && o.sel;
        htrans = o.trans;
        hwrite = o.wr;
        hsize  = o.size;
        haddr  = o.addr;
        hburst = 3'($urandom_range(7));
    endtask

    // Issues the queued ops back to back, overlapping each address phase with the
    // previous data phase, and checks every cycle of the active instance.
    task automatic run(input int w);
        int   ai = 0, waits = 0, phase = 0, guard = 0;
        bit   dv = 1'b0, de = 1'b0;
        op_t  dp;
        logic rdy;
        logic [1:0]  resp;
        logic [31:0] rdata;
        dp = mk(0, 0, 0, 0, 0, 0);
        while ((ai < ops.size() || dv) && guard < 5000) begin
            guard++;
            @(negedge clk);
            rdy   = (w == 1) ? hreadyout1 : hreadyout0;
            resp  = (w == 1) ? hresp1 : hresp0;
            rdata = (w == 1) ? hrdata1 : hrdata0;
            chk("hrdata", rdata, last_rd[w]);
            if (!dv) begin
                chk("idle_ready", 32'(rdy), 32'd1);
                chk("idle_resp", 32'(resp), 32'd0);
            end else if (de) begin
                chk("err_ready", 32'(rdy), (phase == 0) ? 32'd0 : 32'd1);
                chk("err_resp", 32'(resp), 32'd1);
            end else begin
                chk("okay_resp", 32'(resp), 32'd0);
                if (rdy) chk("wait_count", 32'(waits), 32'(ws_of(w)));
                else waits++;
            end
            hwdata = (dv && !de && dp.wr && rdy) ? dp.data : $urandom;
            if (ai < ops.size()) drive(ops[ai], w);
            else drive_idle();
            @(posedge clk);
            if (!rdy) begin
                phase++;
            end else begin
                if (dv && !de && dp.wr) mdl_write(w, dp);
                dv = 1'b0;
                if (ai < ops.size()) begin
                    dp = ops[ai];
                    ai++;
                    if (dp.sel && dp.trans[1]) begin
                        dv = 1'b1; de = is_err(w, dp); waits = 0; phase = 0;
                        if (!de && !dp.wr) last_rd[w] = mdl_word(w, dp.addr);
                    end
                end
            end
        end
        if (guard >= 5000) begin
            checks++;
            errors++;
            $error("FAIL run_timeout observed=%0d cycles required=fewer than 5000", guard);
        end
        ops.delete();
    endtask

    task automatic add_random(input int w, input int n);
        logic [31:0] b = base_of(w) + 32'h400;
        for (int i = 0; i < 16; i++) ops.push_back(mk(1, 2'b10, 1, 3'd2, b + 32'(4*i), $urandom));
        for (int i = 0; i < n; i++) begin
            op_t o;
            int  bo = int'($urandom_range(3));
            o.sel   = ($urandom_range(9) != 0);
            o.trans = 2'($urandom_range(3));
            o.wr    = 1'($urandom_range(1));
            o.size  = ($urandom_range(19) == 0) ? 3'($urandom_range(7, 3)) : 3'($urandom_range(2));
            if (o.size == 3'd1 && $urandom_range(7) != 0) bo = bo & 2;
            if (o.size == 3'd2 && $urandom_range(7) != 0) bo = 0;
            o.addr  = b + 32'(4 * $urandom_range(15)) + 32'(bo);
            if ($urandom_range(15) == 0) o.addr = o.addr + 32'h1000;
            o.data  = $urandom;
            ops.push_back(o);
        end
    endtask

    initial begin
        reset = 1'b1;
        hwdata = 32'h0;
        drive_idle();
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_ready0", 32'(hreadyout0), 32'd1);
        chk("rst_resp0", 32'(hresp0), 32'd0);
        chk("rst_rdata0", hrdata0, 32'h0);
        chk("rst_ready1", 32'(hreadyout1), 32'd1);
        chk("rst_rdata1", hrdata1, 32'h0);

        // zero-wait instance: plain, merged, forwarded and illegal accesses
        ops.push_back(mk(1, 2'b10, 1, 3'd2, B0 + 32'h10, 32'hDEADBEEF));
        ops.push_back(mk(0, 2'b00, 0, 3'd0, 32'h0, 32'h0));
        ops.push_back(mk(1, 2'b10, 0, 3'd2, B0 + 32'h10, 32'h0));
        ops.push_back(mk(1, 2'b10, 1, 3'd2, B0 + 32'h20, 32'h11223344));
        ops.push_back(mk(1, 2'b10, 1, 3'd0, B0 + 32'h22, 32'h00AA0000));
        ops.push_back(mk(1, 2'b11, 1, 3'd1, B0 + 32'h20, 32'h00005566));
        ops.push_back(mk(1, 2'b01, 0, 3'd2, B0 + 32'h20, 32'h0));
        ops.push_back(mk(1, 2'b10, 0, 3'd2, B0 + 32'h20, 32'h0));
        ops.push_back(mk(1, 2'b10, 1, 3'd2, B0 + 32'h30, 32'hCAFEF00D));
        ops.push_back(mk(1, 2'b10, 0, 3'd2, B0 + 32'h30, 32'h0));
        ops.push_back(mk(1, 2'b10, 1, 3'd2, B0 + 32'h40, 32'h01020304));
        ops.push_back(mk(1, 2'b10, 1, 3'd2, B0 + 32'h41, 32'hFFFFFFFF));
        ops.push_back(mk(1, 2'b10, 0, 3'd2, B0 + 32'h41, 32'h0));
        ops.push_back(mk(1, 2'b10, 0, 3'd2, B0 + 32'h1000, 32'h0));
        ops.push_back(mk(1, 2'b10, 0, 3'd1, B0 + 32'h43, 32'h0));
        ops.push_back(mk(1, 2'b10, 0, 3'd3, B0 + 32'h40, 32'h0));
        ops.push_back(mk(1, 2'b10, 1, 3'd0, B0 - 32'h4, 32'h0));
        ops.push_back(mk(1, 2'b10, 0, 3'd2, B0 + 32'h40, 32'h0));
        run(0);
        chk("merge_0x20", mdl_word(0, B0 + 32'h20), 32'h11AA5566);
        add_random(0, 200);
        run(0);

        // two-wait instance
        ops.push_back(mk(1, 2'b10, 1, 3'd2, B1 + 32'h10, 32'hDEADBEEF));
        ops.push_back(mk(1, 2'b10, 0, 3'd2, B1 + 32'h10, 32'h0));
        ops.push_back(mk(1, 2'b10, 1, 3'd2, B1 + 32'h30, 32'hCAFEF00D));
        ops.push_back(mk(1, 2'b10, 0, 3'd2, B1 + 32'h30, 32'h0));
        ops.push_back(mk(1, 2'b10, 1, 3'd2, B1 + 32'h50, 32'h12345678));
        ops.push_back(mk(1, 2'b10, 0, 3'd1, B1 + 32'h51, 32'h0));
        run(1);

        // reset lands in the middle of a write's wait states
        @(negedge clk);
        hsel1 = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = B1 + 32'h50;
        @(posedge clk);
        @(negedge clk);
        chk("rst_wait_ready", 32'(hreadyout1), 32'd0);
        drive_idle();
        hwdata = 32'h0BADF00D;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_ready", 32'(hreadyout1), 32'd1);
        chk("rst_mid_resp", 32'(hresp1), 32'd0);
        chk("rst_mid_rdata", hrdata1, 32'h0);
        chk("rst_mid_rdata0", hrdata0, 32'h0);
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;

        ops.push_back(mk(1, 2'b10, 0, 3'd2, B1 + 32'h50, 32'h0));
        run(1);
        chk("rst_keeps_0x50", mdl_word(1, B1 + 32'h50), 32'h12345678);
        ops.push_back(mk(1, 2'b10, 0, 3'd2, B0 + 32'h10, 32'h0));
        run(0);
        add_random(1, 120);
        run(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
